// File: rtl/seq_pkg.sv
// Shared types and constants for the front-panel switch sequencer.
// Optional debounce counter is selected with SWITCH_SEQ_DEBOUNCE_EN.
package seq_pkg;

  typedef enum logic [2:0] {
    WAIT_X = 3'd0,
    X_RDY  = 3'd1,
    WAIT_Y = 3'd2,
    Y_RDY  = 3'd3,
    RUN    = 3'd4,
    SHOW0  = 3'd5,
    SHOW1  = 3'd6
  } seq_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;

  localparam int SW_LOAD  = 8;
  localparam int SW_ABORT = 9;

endpackage

// File: rtl/switch_sequencer_debounce.sv
// Button conditioner: 2-flop synchroniser, optional stability counter
// (SWITCH_SEQ_DEBOUNCE_EN) and a one-cycle rising-edge pulse.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_range
    $error("DEBOUNCE_CYCLES out of range 1..255");
  end

  logic s1;
  logic s2;
  logic level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

`ifdef SWITCH_SEQ_DEBOUNCE_EN
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] cnt;
  logic       db;

  // Level flips only after LAST+1 consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (s2 != db) begin
      if (cnt == LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign level = db;
`else
  assign level = s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/switch_sequencer.sv
// Front-panel sequencer: latches two switch operands for the CPU, collects two
// results and steps the LEDs through them. Debounce set by SWITCH_SEQ_DEBOUNCE_EN.
module switch_sequencer
  import seq_pkg::*;
#(
  parameter int n               = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic [9:0]   Switches,
  output logic [n-1:0] InData,
  output logic         InValid,
  input  logic         InAck,
  input  logic [n-1:0] OutData,
  input  logic         OutWrite,
  output logic [n-1:0] LEDs,
  output logic [2:0]   Phase
);

  localparam int OPW = (n < 8) ? n : 8;

  function automatic logic [n-1:0] fit(input logic [7:0] v);
    logic [n-1:0] r;
    r          = '0;
    r[OPW-1:0] = v[OPW-1:0];
    return r;
  endfunction

  seq_state_t   state;
  logic [n-1:0] r0;
  logic [n-1:0] r1;
  logic         got0;
  logic         press;
  logic         load_level;
  logic [8:0]   sw_s1;
  logic [8:0]   sw_s2;
  logic         abort;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk   (Clock),
    .rst_n (nReset),
    .raw   (Switches[SW_LOAD]),
    .level (load_level),
    .rise  (press)
  );

  // Abort and the live operand bits (LED display only) share a plain synchroniser.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= {Switches[SW_ABORT], Switches[7:0]};
      sw_s2 <= sw_s1;
    end
  end

  assign abort = sw_s2[8];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= WAIT_X;
      InData  <= '0;
      InValid <= 1'b0;
      r0      <= '0;
      r1      <= '0;
      got0    <= 1'b0;
      LEDs    <= '0;
    end else begin
      if (abort) begin
        state   <= WAIT_X;
        InValid <= 1'b0;
        r0      <= '0;
        r1      <= '0;
        got0    <= 1'b0;
      end else begin
        case (state)
          WAIT_X: if (press) begin
            InData  <= fit(Switches[7:0]);
            InValid <= 1'b1;
            state   <= X_RDY;
          end
          X_RDY: if (InAck) begin
            InValid <= 1'b0;
            state   <= WAIT_Y;
          end
          WAIT_Y: if (press) begin
            InData  <= fit(Switches[7:0]);
            InValid <= 1'b1;
            state   <= Y_RDY;
          end
          Y_RDY: if (InAck) begin
            InValid <= 1'b0;
            state   <= RUN;
          end
          RUN: if (OutWrite) begin
            if (!got0) begin
              r0   <= OutData;
              got0 <= 1'b1;
            end else begin
              r1    <= OutData;
              state <= SHOW0;
            end
          end
          SHOW0: if (press) state <= SHOW1;
          SHOW1: if (press) begin
            state <= WAIT_X;
            r0    <= '0;
            r1    <= '0;
            got0  <= 1'b0;
          end
          default: state <= WAIT_X;
        endcase
      end

      // Display follows the state held during the previous cycle.
      case (state)
        WAIT_X, WAIT_Y:    LEDs <= fit(sw_s2[7:0]);
        X_RDY, Y_RDY, RUN: LEDs <= InData;
        SHOW0:             LEDs <= r0;
        SHOW1:             LEDs <= r1;
        default:           LEDs <= '0;
      endcase
    end
  end

  assign Phase = state;

  logic unused_level;
  assign unused_level = load_level;

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed/randomised bench for switch_sequencer with a result-queue reference model.
module tb_switch_sequencer;

  localparam int N  = 8;
  localparam int DB = 4;
`ifdef SWITCH_SEQ_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 2;
`endif

  logic         Clock = 1'b0;
  logic         nReset = 1'b0;
  logic [9:0]   Switches = '0;
  logic [N-1:0] InData;
  logic         InValid;
  logic         InAck = 1'b0;
  logic [N-1:0] OutData = '0;
  logic         OutWrite = 1'b0;
  logic [N-1:0] LEDs;
  logic [2:0]   Phase;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: results written while the sequencer is running.
  logic [7:0] res_q[$];

  switch_sequencer #(.n(N), .DEBOUNCE_CYCLES(DB)) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .Switches (Switches),
    .InData   (InData),
    .InValid  (InValid),
    .InAck    (InAck),
    .OutData  (OutData),
    .OutWrite (OutWrite),
    .LEDs     (LEDs),
    .Phase    (Phase)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic press_rise();
    Switches[8] = 1'b1;
    tick(LAT + 1);
  endtask

  task automatic press_fall();
    Switches[8] = 1'b0;
    tick(LAT + 2);
  endtask

  task automatic ack();
    InAck = 1'b1;
    tick(1);
    InAck = 1'b0;
  endtask

  task automatic write(input logic [7:0] v, input bit in_run);
    OutData  = v;
    OutWrite = 1'b1;
    tick(1);
    OutWrite = 1'b0;
    if (in_run) res_q.push_back(v);
  endtask

  task automatic run_seq(input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] a, input logic [7:0] b, input bit stray);
    res_q.delete();
    Switches[7:0] = x;
    tick(4);
    check("led_wait_x", int'(LEDs), int'(x));
    if (stray) begin
      ack();
      check("stray_ack_vld", int'(InValid), 0);
      check("stray_ack_ph", int'(Phase), 0);
    end
    press_rise();
    check("ph_x_rdy", int'(Phase), 1);
    check("vld_x", int'(InValid), 1);
    check("data_x", int'(InData), int'(x));
    press_fall();
    check("led_x_rdy", int'(LEDs), int'(x));
    ack();
    check("vld_ack_x", int'(InValid), 0);
    check("ph_wait_y", int'(Phase), 2);
    if (stray) begin
      write(8'hAA, 1'b0);
      check("stray_wr_r0", int'(dut.r0), 0);
    end
    Switches[7:0] = y;
    tick(4);
    check("led_wait_y", int'(LEDs), int'(y));
    press_rise();
    check("ph_y_rdy", int'(Phase), 3);
    check("data_y", int'(InData), int'(y));
    press_fall();
    ack();
    check("ph_run", int'(Phase), 4);
    check("vld_ack_y", int'(InValid), 0);
    write(a, 1'b1);
    check("ph_run_1wr", int'(Phase), 4);
    if (stray) begin
      press_rise();
      check("press_in_run", int'(Phase), 4);
      press_fall();
    end
    write(b, 1'b1);
    check("ph_show0", int'(Phase), 5);
    tick(1);
    check("led_show0", int'(LEDs), int'(res_q[0]));
    press_rise();
    check("ph_show1", int'(Phase), 6);
    press_fall();
    check("led_show1", int'(LEDs), int'(res_q[1]));
    press_rise();
    check("ph_back_x", int'(Phase), 0);
    press_fall();
  endtask

  initial begin
    #2;
    check("rst_indata", int'(InData), 0);
    check("rst_invalid", int'(InValid), 0);
    check("rst_leds", int'(LEDs), 0);
    check("rst_phase", int'(Phase), 0);
    tick(2);
    nReset = 1'b1;
    tick(2);

    // Button bounce (debounced) or single glitch (raw) as the first press.
    Switches[7:0] = 8'h5A;
`ifdef SWITCH_SEQ_DEBOUNCE_EN
    Switches[8] = 1'b1;
    tick(3);
    Switches[8] = 1'b0;
    tick(2);
    Switches[8] = 1'b1;
    tick(LAT);
    check("bounce_early", int'(Phase), 0);
    tick(1);
    check("bounce_press", int'(Phase), 1);
    Switches[8] = 1'b0;
    tick(LAT + 2);
`else
    Switches[8] = 1'b1;
    tick(1);
    Switches[8] = 1'b0;
    tick(LAT - 1);
    check("glitch_early", int'(Phase), 0);
    tick(1);
    check("glitch_press", int'(Phase), 1);
    tick(LAT + 2);
`endif
    check("bounce_data", int'(InData), 32'h5A);
    ack();
    check("bounce_ack_ph", int'(Phase), 2);

    // Abort from WAIT_Y returns to idle.
    Switches[9] = 1'b1;
    tick(3);
    check("abort_wy_ph", int'(Phase), 0);
    Switches[9] = 1'b0;
    tick(4);

    run_seq(8'h12, 8'h34, 8'h34, 8'h12, 1'b1);

    for (int it = 0; it < 4; it++) begin
      run_seq(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
    end

    // Abort in RUN after one result.
    Switches[7:0] = 8'h21;
    press_rise();
    press_fall();
    ack();
    Switches[7:0] = 8'h43;
    press_rise();
    press_fall();
    ack();
    check("abort_pre_run", int'(Phase), 4);
    write(8'h77, 1'b1);
    res_q.delete();
    Switches[9] = 1'b1;
    tick(2);
    check("abort_ph_2cyc", int'(Phase), 4);
    tick(1);
    check("abort_ph_3cyc", int'(Phase), 0);
    check("abort_vld", int'(InValid), 0);
    check("abort_r0_clr", int'(dut.r0), 0);
    Switches[9] = 1'b0;
    tick(4);
    run_seq(8'h9C, 8'h3E, 8'hC3, 8'h5D, 1'b0);

    // Asynchronous reset in Y_RDY, mid-cycle.
    Switches[7:0] = 8'h66;
    press_rise();
    press_fall();
    ack();
    Switches[7:0] = 8'h99;
    press_rise();
    press_fall();
    check("pre_rst_ph", int'(Phase), 3);
    @(posedge Clock);
    #3;
    nReset = 1'b0;
    #1;
    check("arst_invalid", int'(InValid), 0);
    check("arst_leds", int'(LEDs), 0);
    check("arst_phase", int'(Phase), 0);
    tick(2);
    nReset = 1'b1;
    tick(2);
    check("post_rst_data", int'(InData), 0);
    check("post_rst_ph", int'(Phase), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
